// File: rtl/ip_stream_scheduler_pkg.sv
// Shared types and helpers for the IPv4 stream scheduler.
// Optional statistics counters are enabled with IP_STREAM_SCHEDULER_STATS_EN.
package ip_stream_scheduler_pkg;

    localparam int CREDIT_W_DEF = 20;
    localparam int FRAC_W_DEF   = 8;
    localparam int MAX_STREAMS  = 16;

    typedef enum logic [1:0] {ARB, HDR, PAYLOAD} sched_state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit of eligible searching upward from ptr+1, wrapping modulo n.
    // Scanning from the far end down lets the nearest candidate win last.
    function automatic rr_pick_t rr_pick(input logic [MAX_STREAMS-1:0] eligible,
                                         input logic [3:0] ptr, input int n);
        rr_pick_t r;
        int       cand;
        r = '0;
        for (int k = MAX_STREAMS; k >= 1; k--) begin
            cand = (int'(ptr) + k) % n;
            if (k <= n && eligible[4'(cand)]) begin
                r.found = 1'b1;
                r.idx   = 4'(cand);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ip_sched_token_bucket.sv
// Per-stream token bucket: fixed-point credit that refills every cycle,
// is charged a frame cost on grant and saturates at the configured burst.
module ip_sched_token_bucket
    import ip_stream_scheduler_pkg::*;
#(
    parameter int CREDIT_W = CREDIT_W_DEF,
    parameter int FRAC_W   = FRAC_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       req_valid,
    input  logic                       deduct,
    input  logic [7+FRAC_W:0]          rate,
    input  logic [CREDIT_W-1:0]        burst,
    input  logic [15:0]                length,
    output logic [CREDIT_W+FRAC_W-1:0] credit,
    output logic                       eligible
);

    localparam int CW = CREDIT_W + FRAC_W;

    // One guard bit so refill on top of a full bucket never wraps.
    logic [CW:0] cost, ceiling, sum;

    assign cost     = (CW+1)'(length) << FRAC_W;
    assign ceiling  = (CW+1)'(burst) << FRAC_W;
    // A deduct only follows an eligible cycle, so the subtraction cannot underflow.
    assign sum      = {1'b0, credit} + (CW+1)'(rate) - (deduct ? cost : '0);
    assign eligible = req_valid & enable & ({1'b0, credit} >= cost);

    // Credit register: cleared while disabled, otherwise refilled and capped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            credit <= '0;
        else if (!enable)
            credit <= '0;
        else if (sum > ceiling)
            credit <= ceiling[CW-1:0];
        else
            credit <= sum[CW-1:0];
    end

endmodule

// File: rtl/ip_stream_scheduler.sv
// Round-robin, rate-shaped sharing of one IPv4 header+payload path.
// Define IP_STREAM_SCHEDULER_STATS_EN to add per-stream packet/stall counters.
module ip_stream_scheduler
    import ip_stream_scheduler_pkg::*;
#(
    parameter int NUM_STREAMS = 4,
    parameter int CREDIT_W    = CREDIT_W_DEF,
    parameter int FRAC_W      = FRAC_W_DEF,
    parameter int SEL_W       = $clog2(NUM_STREAMS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_STREAMS-1:0]                s_req_valid,
    output logic [NUM_STREAMS-1:0]                s_req_ready,
    input  logic [NUM_STREAMS-1:0][15:0]          s_req_length,
    input  logic [NUM_STREAMS-1:0][7:0]           s_payload_tdata,
    input  logic [NUM_STREAMS-1:0]                s_payload_tvalid,
    output logic [NUM_STREAMS-1:0]                s_payload_tready,
    input  logic [NUM_STREAMS-1:0]                s_payload_tlast,
    input  logic [NUM_STREAMS-1:0]                s_payload_tuser,
    output logic                                  m_hdr_valid,
    input  logic                                  m_hdr_ready,
    output logic [SEL_W-1:0]                      m_hdr_sel,
    output logic [7:0]                            m_payload_tdata,
    output logic                                  m_payload_tvalid,
    input  logic                                  m_payload_tready,
    output logic                                  m_payload_tlast,
    output logic                                  m_payload_tuser,
    input  logic [NUM_STREAMS-1:0]                cfg_enable,
    input  logic [NUM_STREAMS-1:0][7+FRAC_W:0]    cfg_rate,
    input  logic [NUM_STREAMS-1:0][CREDIT_W-1:0]  cfg_burst,
`ifdef IP_STREAM_SCHEDULER_STATS_EN
    input  logic                                  stat_clear,
    output logic [NUM_STREAMS-1:0][31:0]          stat_pkt_cnt,
    output logic [NUM_STREAMS-1:0][31:0]          stat_stall_cnt,
`endif
    output logic                                  busy
);

    sched_state_e                  state_q, state_d;
    logic [SEL_W-1:0]              rr_ptr_q, sel_q, win;
    logic [NUM_STREAMS-1:0]        eligible, deduct;
    logic [MAX_STREAMS-1:0]        elig_ext;
    rr_pick_t                      pick;

    for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_bkt
        ip_sched_token_bucket #(.CREDIT_W(CREDIT_W), .FRAC_W(FRAC_W)) u_bkt (
            .clk       (clk),
            .rst       (rst),
            .enable    (cfg_enable[i]),
            .req_valid (s_req_valid[i]),
            .deduct    (deduct[i]),
            .rate      (cfg_rate[i]),
            .burst     (cfg_burst[i]),
            .length    (s_req_length[i]),
            .credit    (),
            .eligible  (eligible[i])
        );
    end

    assign elig_ext    = MAX_STREAMS'(eligible);
    assign pick        = rr_pick(elig_ext, 4'(rr_ptr_q), NUM_STREAMS);
    assign win         = SEL_W'(pick.idx);
    assign m_hdr_valid = (state_q == HDR);
    assign m_hdr_sel   = sel_q;
    assign busy        = (state_q != ARB);

    // State, grant index and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB;
            rr_ptr_q <= SEL_W'(NUM_STREAMS - 1);
            sel_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB && pick.found) begin
                sel_q    <= win;
                rr_ptr_q <= win;
            end
        end
    end

    // Next state, credit charge on grant, and handshake steering to the granted stream.
    always_comb begin
        state_d          = state_q;
        deduct           = '0;
        s_req_ready      = '0;
        s_payload_tready = '0;
        m_payload_tdata  = '0;
        m_payload_tvalid = 1'b0;
        m_payload_tlast  = 1'b0;
        m_payload_tuser  = 1'b0;
        case (state_q)
            ARB: begin
                if (pick.found) begin
                    state_d     = HDR;
                    deduct[win] = 1'b1;
                end
            end
            HDR: begin
                s_req_ready[sel_q] = m_hdr_ready;
                if (m_hdr_ready)
                    state_d = PAYLOAD;
            end
            PAYLOAD: begin
                m_payload_tdata         = s_payload_tdata[sel_q];
                m_payload_tvalid        = s_payload_tvalid[sel_q];
                m_payload_tlast         = s_payload_tlast[sel_q];
                m_payload_tuser         = s_payload_tuser[sel_q];
                s_payload_tready[sel_q] = m_payload_tready;
                if (s_payload_tvalid[sel_q] && m_payload_tready && s_payload_tlast[sel_q])
                    state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

`ifdef IP_STREAM_SCHEDULER_STATS_EN
    logic [NUM_STREAMS-1:0] tlast_beat, stall;

    assign tlast_beat = s_payload_tvalid & s_payload_tready & s_payload_tlast;
    assign stall      = s_req_valid & cfg_enable & ~eligible;

    // Saturating per-stream packet and credit-stall counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pkt_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else if (stat_clear) begin
            stat_pkt_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (tlast_beat[i] && stat_pkt_cnt[i] != '1)
                    stat_pkt_cnt[i] <= stat_pkt_cnt[i] + 32'd1;
                if (stall[i] && stat_stall_cnt[i] != '1)
                    stat_stall_cnt[i] <= stat_stall_cnt[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ip_stream_scheduler.md
Name: ip_stream_scheduler

Overview:
- Shares one IPv4 transmit path (header handshake followed by an 8-bit payload stream into ip_eth_tx) between NUM_STREAMS packet requesters.
- Round-robin arbitration, gated by a per-stream token-bucket rate shaper.
- The granted stream keeps the path from header acceptance until its payload tlast handshake.
- Sits between the packet generators and ip_eth_tx; downstream uses m_hdr_sel to mux header fields.

Parameters:
- NUM_STREAMS, 4, number of requesters (2..16).
- CREDIT_W, 20, integer bits of the credit counter in bytes.
- FRAC_W, 8, fractional bits of refill rate and credit.
- SEL_W, $clog2(NUM_STREAMS), grant index width (derived).

Ports:
- clk  in  1  block clock.
- rst  in  1  asynchronous active-high reset.
- s_req_valid  in  NUM_STREAMS  per-stream header request.
- s_req_ready  out  NUM_STREAMS  per-stream header accepted.
- s_req_length  in  NUM_STREAMS*16  per-stream frame cost in bytes.
- s_payload_tdata  in  NUM_STREAMS*8  per-stream payload data.
- s_payload_tvalid  in  NUM_STREAMS  per-stream payload valid.
- s_payload_tready  out  NUM_STREAMS  per-stream payload ready.
- s_payload_tlast  in  NUM_STREAMS  per-stream payload last.
- s_payload_tuser  in  NUM_STREAMS  per-stream payload error flag.
- m_hdr_valid  out  1  header valid to ip_eth_tx.
- m_hdr_ready  in  1  header ready from ip_eth_tx.
- m_hdr_sel  out  SEL_W  index of the granted stream.
- m_payload_tdata  out  8  payload data to ip_eth_tx.
- m_payload_tvalid  out  1  payload valid to ip_eth_tx.
- m_payload_tready  in  1  payload ready from ip_eth_tx.
- m_payload_tlast  out  1  payload last to ip_eth_tx.
- m_payload_tuser  out  1  payload error flag to ip_eth_tx.
- cfg_enable  in  NUM_STREAMS  per-stream enable.
- cfg_rate  in  NUM_STREAMS*(8+FRAC_W)  refill in bytes per cycle, unsigned Q8.FRAC_W.
- cfg_burst  in  NUM_STREAMS*CREDIT_W  credit ceiling in bytes.
- busy  out  1  high in the HDR and PAYLOAD states.

Behaviour:
- Reset (asynchronous): state=ARB, rr_ptr=NUM_STREAMS-1, all credits=0, m_hdr_valid=0, m_hdr_sel=0, busy=0. All s_req_ready, s_payload_tready and m_payload_tvalid are 0.
- Credit update, every cycle, per stream:
  - Compute credit + rate - (deduct ? length<<FRAC_W : 0).
  - Saturate at burst<<FRAC_W.
  - Width CREDIT_W+FRAC_W; the intermediate sum is one bit wider, so it never wraps.
  - When cfg_enable=0, credit is forced to 0.
- Eligible[i] = s_req_valid[i] & cfg_enable[i] & (credit[i] >= s_req_length[i]<<FRAC_W). Credit never goes negative.
- State ARB:
  - Pick the first eligible index searching from rr_ptr+1, wrapping modulo NUM_STREAMS.
  - If one is found, register it in m_hdr_sel, set rr_ptr to it and go to HDR; m_hdr_valid=1 on the next cycle (1-cycle arbitration latency).
  - Deduct the winner's cost in the same cycle as the grant.
  - No eligible stream: stay in ARB.
- State HDR:
  - m_hdr_valid held at 1; s_req_ready[sel]=m_hdr_ready combinationally; all other s_req_ready are 0.
  - On m_hdr_valid&m_hdr_ready, go to PAYLOAD.
  - Granted requester must hold its header stable until accepted. Dropping s_req_valid in HDR is a protocol violation; the block still waits for m_hdr_ready.
- State PAYLOAD:
  - m_payload_* is a combinational mux of stream sel; s_payload_tready[sel]=m_payload_tready; all other treadys are 0.
  - On a tvalid&tready&tlast beat, return to ARB. Re-arbitration happens on the next cycle, so there is at least 1 idle cycle between packets.
- Payload from any stream is blocked (tready=0) outside PAYLOAD.
- cfg_enable[sel] dropping mid-packet: the packet completes and the credit is zeroed.
- cfg_rate/cfg_burst changes take effect on the next cycle; no CDC is performed.
- Streams with cfg_rate=0 are eligible only while residual credit covers the frame cost.
- A stream with cost greater than burst never becomes eligible; this is documented, not flagged.

Optional Feature:
- Macro: IP_STREAM_SCHEDULER_STATS_EN.
- Defined: adds stat_pkt_cnt (NUM_STREAMS*32, out) and stat_stall_cnt (NUM_STREAMS*32, out).
  - stat_pkt_cnt increments on each tlast beat of that stream.
  - stat_stall_cnt increments each cycle that s_req_valid&cfg_enable is high but the stream is ineligible for lack of credit.
  - Both saturate at 2^32-1; both are cleared by rst and by a stat_clear input (1 bit, in).
- Undefined: ports and counters are absent.

Decomposition:
- Package ip_stream_scheduler_pkg: CREDIT_W/FRAC_W defaults, state enum {ARB, HDR, PAYLOAD}, and a function rr_pick(eligible, ptr) returning the found flag and index.
- Sub-module ip_sched_token_bucket: one instance per stream. It holds the credit register and saturating update, and outputs eligible.

Test Plan:
- NUM_STREAMS=4; all enabled; rate=8.0; burst=4096; every stream requests length 64 continuously -> grants in order 0,1,2,3,0; each grant follows the previous tlast by 2 cycles.
- Only stream 2 enabled; rate=0.5 (0x080 at FRAC_W=8); length 100 -> first grant at cycle 200 after reset; each following grant comes 200 cycles after the previous one's deduction.
- burst=50, length=64 -> stream never granted; with STATS_EN, stat_stall_cnt increments every cycle.
- m_hdr_ready held low for 10 cycles -> m_hdr_valid and m_hdr_sel held stable; no s_payload_tready asserted; the grant is retained.
- rst asserted mid-payload of stream 1 -> all outputs 0 immediately (asynchronous), credits 0; the first grant after release goes to stream 0.
- cfg_enable[3] cleared during stream 3 payload -> packet completes through tlast, then stream 3 credit reads 0 and it is not granted.
